reg_scoreboard: RTL and testbench

Register scoreboard for the 5-stage RISC-V pipeline. It tracks in-flight writes to each architectural register: the count goes up when a writing instruction leaves ID, and down when it retires at WB or is squashed. From that state it produces the stall controls for the PC, the IF/ID register and the ID/EX bubble mux. It is the state-holding, write-tracking counterpart of the combinational hazard check, and it replaces pairwise register comparisons with a per-register pending count, so multi-cycle writers are covered.

---
 rtl/reg_scoreboard.sv | 112 +++++++++++
 tb/tb_reg_scoreboard.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_scoreboard.sv
// Per-register pending-write scoreboard for the 5-stage pipeline: counts in-flight
// writers per architectural register and derives PC / IF-ID / bubble stall controls.
module reg_scoreboard #(
  parameter int CNT_W  = 2,
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [4:0]        id_rs1,
  input  logic              id_rs1_used,
  input  logic [4:0]        id_rs2,
  input  logic              id_rs2_used,
  input  logic [4:0]        id_rd,
  input  logic              id_reg_write,
  input  logic              wb_valid,
  input  logic [4:0]        wb_rd,
  input  logic              wb_reg_write,
  input  logic              kill_valid,
  input  logic [4:0]        kill_rd,
  input  logic              kill_reg_write,
  output logic              PC_En,
  output logic              IF_ID_En,
  output logic              Mux_sel,
  output logic [31:0]       busy,
  output logic [PERF_W-1:0] stall_cycles
);

  localparam int EW = CNT_W + 2;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0]  r_count [1:31];
  logic [31:0]       r_busy;
  logic [PERF_W-1:0] r_stall_cycles;

  logic [CNT_W-1:0] w_cnt  [32];
  logic [1:0]       w_dec  [32];
  logic [CNT_W-1:0] w_next [32];
  logic [31:0]      w_inc;
  logic [31:0]      w_underflow;
  logic             w_raw1;
  logic             w_raw2;
  logic             w_sat;
  logic             w_stall;

  // x0 has no storage; it reads as a permanently empty counter.
  always_comb begin
    w_cnt[0] = '0;
    for (int r = 1; r < 32; r++) w_cnt[r] = r_count[r];
  end

  always_comb begin
    for (int r = 0; r < 32; r++) begin
      w_dec[r] = 2'(wb_valid & wb_reg_write & (wb_rd == 5'(r)))
               + 2'(kill_valid & kill_reg_write & (kill_rd == 5'(r)));
    end
  end

  // A writer retiring this cycle already resolves the hazard (write-before-read RF).
  always_comb begin
    w_raw1  = id_rs1_used & (id_rs1 != 5'd0) & (EW'(w_cnt[id_rs1]) != EW'(w_dec[id_rs1]));
    w_raw2  = id_rs2_used & (id_rs2 != 5'd0) & (EW'(w_cnt[id_rs2]) != EW'(w_dec[id_rs2]));
    w_sat   = id_valid & id_reg_write & (id_rd != 5'd0)
            & (w_cnt[id_rd] == CNT_MAX) & (w_dec[id_rd] == 2'd0);
    w_stall = rst_n & ((id_valid & (w_raw1 | w_raw2)) | w_sat);
  end

  assign PC_En    = ~w_stall;
  assign IF_ID_En = ~w_stall;
  assign Mux_sel  = w_stall;

  always_comb begin
    logic [EW-1:0] v_sum;
    for (int r = 0; r < 32; r++) begin
      w_inc[r]       = id_valid & id_reg_write & (id_rd == 5'(r)) & (r != 0) & ~w_stall;
      w_underflow[r] = 1'b0;
      w_next[r]      = '0;
      v_sum          = EW'(w_cnt[r]) + EW'(w_inc[r]);
      if (r != 0) begin
        if (v_sum < EW'(w_dec[r])) begin
          w_underflow[r] = 1'b1;
        end else begin
          w_next[r] = CNT_W'(v_sum - EW'(w_dec[r]));
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 1; r < 32; r++) r_count[r] <= '0;
      r_busy         <= '0;
      r_stall_cycles <= '0;
    end else begin
      for (int r = 1; r < 32; r++) begin
        r_count[r] <= w_next[r];
        r_busy[r]  <= (w_next[r] != '0);
      end
      r_busy[0] <= 1'b0;
      if (w_stall) r_stall_cycles <= r_stall_cycles + 1'b1;
    end
  end

  assign busy         = r_busy;
  assign stall_cycles = r_stall_cycles;

`ifndef SYNTHESIS
  // Retiring or squashing a register with no pending writer is a pipeline bug.
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n) (w_underflow == 32'd0));
`endif

endmodule

// File: tb/tb_reg_scoreboard.sv
// Bench for reg_scoreboard: directed hazard scenarios then random traffic, all
// checked against an integer-count reference model of the scoreboard rules.
module tb_reg_scoreboard;

  localparam int CNT_W  = 2;
  localparam int PERF_W = 32;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              id_valid, id_rs1_used, id_rs2_used, id_reg_write;
  logic [4:0]        id_rs1, id_rs2, id_rd;
  logic              wb_valid, wb_reg_write;
  logic [4:0]        wb_rd;
  logic              kill_valid, kill_reg_write;
  logic [4:0]        kill_rd;
  logic              PC_En, IF_ID_En, Mux_sel;
  logic [31:0]       busy;
  logic [PERF_W-1:0] stall_cycles;

  int                m_cnt [32];
  logic [PERF_W-1:0] m_stalls;
  logic              m_stall;
  int                n_checks = 0;
  int                n_pass = 0;

  reg_scoreboard #(.CNT_W(CNT_W), .PERF_W(PERF_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs1_used(id_rs1_used),
    .id_rs2(id_rs2), .id_rs2_used(id_rs2_used), .id_rd(id_rd), .id_reg_write(id_reg_write),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .kill_valid(kill_valid), .kill_rd(kill_rd), .kill_reg_write(kill_reg_write),
    .PC_En(PC_En), .IF_ID_En(IF_ID_En), .Mux_sel(Mux_sel),
    .busy(busy), .stall_cycles(stall_cycles)
  );

  // clock
  always #5 clk = ~clk;

  // reference model
  function automatic int dec_of(int r);
    int d = 0;
    if (wb_valid && wb_reg_write && int'(wb_rd) == r) d++;
    if (kill_valid && kill_reg_write && int'(kill_rd) == r) d++;
    return d;
  endfunction

  function automatic logic pending(int r);
    return (r != 0) && (m_cnt[r] - dec_of(r) != 0);
  endfunction

  function automatic logic model_stall();
    logic raw, sat;
    raw = id_valid && ((id_rs1_used && pending(int'(id_rs1))) ||
                       (id_rs2_used && pending(int'(id_rs2))));
    sat = id_valid && id_reg_write && id_rd != 0 &&
          m_cnt[id_rd] == CMAX && dec_of(int'(id_rd)) == 0;
    return raw || sat;
  endfunction

  function automatic logic [31:0] model_busy();
    logic [31:0] b = '0;
    for (int r = 1; r < 32; r++) b[r] = (m_cnt[r] != 0);
    return b;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 32; r++) m_cnt[r] = 0;
    m_stalls = '0;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // drivers
  task automatic idle();
    id_valid = 0; id_rs1 = 0; id_rs1_used = 0; id_rs2 = 0; id_rs2_used = 0;
    id_rd = 0; id_reg_write = 0;
    wb_valid = 0; wb_rd = 0; wb_reg_write = 0;
    kill_valid = 0; kill_rd = 0; kill_reg_write = 0;
  endtask

  task automatic drive_id(input logic v, input int rs1, input logic u1, input int rs2,
                          input logic u2, input int rd, input logic rw);
    id_valid = v; id_rs1 = 5'(rs1); id_rs1_used = u1; id_rs2 = 5'(rs2);
    id_rs2_used = u2; id_rd = 5'(rd); id_reg_write = rw;
  endtask

  task automatic drive_wb(input logic v, input int rd, input logic rw);
    wb_valid = v; wb_rd = 5'(rd); wb_reg_write = rw;
  endtask

  task automatic drive_kill(input logic v, input int rd, input logic rw);
    kill_valid = v; kill_rd = 5'(rd); kill_reg_write = rw;
  endtask

  // combinational outputs, sampled after inputs settle
  task automatic eval(input string tag);
    #1;
    m_stall = model_stall();
    check({tag, ".mux_sel"}, 64'(Mux_sel), 64'(m_stall));
    check({tag, ".pc_en"}, 64'(PC_En), 64'(!m_stall));
    check({tag, ".if_id_en"}, 64'(IF_ID_En), 64'(!m_stall));
  endtask

  // clock edge: advance the model, then sample registered outputs
  task automatic tick(input string tag);
    int n;
    @(posedge clk);
    for (int r = 1; r < 32; r++) begin
      n = m_cnt[r] - dec_of(r);
      if (!m_stall && id_valid && id_reg_write && int'(id_rd) == r) n++;
      m_cnt[r] = (n < 0) ? 0 : n;
    end
    if (m_stall) m_stalls++;
    #1;
    check({tag, ".busy"}, 64'(busy), 64'(model_busy()));
    check({tag, ".stall_cycles"}, 64'(stall_cycles), 64'(m_stalls));
  endtask

  initial begin
    int r, k, avail;
    idle();
    model_reset();
    m_stall = 0;

    // reset state
    #3;
    check("reset.pc_en", 64'(PC_En), 64'd1);
    check("reset.if_id_en", 64'(IF_ID_En), 64'd1);
    check("reset.mux_sel", 64'(Mux_sel), 64'd0);
    check("reset.busy", 64'(busy), 64'd0);
    check("reset.stall_cycles", 64'(stall_cycles), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk) #1;

    // RAW back-to-back: add x5 then sub x6,x5,x1 stalls until x5 retires
    drive_id(1, 0, 0, 0, 0, 5, 1);
    eval("raw.c0"); tick("raw.c0");
    drive_id(1, 5, 1, 1, 1, 6, 1);
    for (int c = 1; c <= 3; c++) begin
      eval("raw.stall");
      check("raw.stall.mux_const", 64'(Mux_sel), 64'd1);
      check("raw.stall.pc_const", 64'(PC_En), 64'd0);
      tick("raw.stall");
    end
    drive_wb(1, 5, 1);
    eval("raw.c4");
    check("raw.release_const", 64'(Mux_sel), 64'd0);
    tick("raw.c4");
    check("raw.busy5_clear", 64'(busy[5]), 64'd0);
    check("raw.stall_count", 64'(stall_cycles), 64'd3);
    idle();

    // x0 destination is never tracked
    drive_id(1, 0, 0, 0, 0, 0, 1);
    eval("x0.write"); tick("x0.write");
    drive_id(1, 0, 1, 0, 1, 0, 1);
    eval("x0.read");
    check("x0.no_stall", 64'(Mux_sel), 64'd0);
    tick("x0.read");
    check("x0.busy0", 64'(busy[0]), 64'd0);
    idle();

    // same-cycle retire and issue on x7 nets to no change
    drive_id(1, 0, 0, 0, 0, 7, 1);
    eval("same.issue"); tick("same.issue");
    drive_id(1, 0, 0, 0, 0, 7, 1);
    drive_wb(1, 7, 1);
    eval("same.both");
    check("same.no_stall", 64'(Mux_sel), 64'd0);
    tick("same.both");
    check("same.busy7", 64'(busy[7]), 64'd1);
    idle();
    drive_wb(1, 7, 1);
    eval("same.retire"); tick("same.retire");
    check("same.busy7_clear", 64'(busy[7]), 64'd0);
    idle();

    // saturation on x9
    drive_id(1, 0, 0, 0, 0, 9, 1);
    for (int c = 0; c < 3; c++) begin
      eval("sat.fill"); tick("sat.fill");
    end
    eval("sat.full");
    check("sat.stall", 64'(Mux_sel), 64'd1);
    tick("sat.full");
    drive_wb(1, 9, 1);
    eval("sat.release");
    check("sat.release_const", 64'(Mux_sel), 64'd0);
    tick("sat.release");
    idle();
    drive_wb(1, 9, 1);
    for (int c = 0; c < 3; c++) begin
      eval("sat.drain"); tick("sat.drain");
    end
    check("sat.busy9_clear", 64'(busy[9]), 64'd0);
    idle();

    // flush: kill of x12 resolves a same-cycle reader
    drive_id(1, 0, 0, 0, 0, 12, 1);
    eval("flush.issue"); tick("flush.issue");
    drive_id(1, 12, 1, 0, 0, 13, 0);
    drive_kill(1, 12, 1);
    eval("flush.kill");
    check("flush.no_stall", 64'(Mux_sel), 64'd0);
    tick("flush.kill");
    check("flush.busy12", 64'(busy[12]), 64'd0);
    idle();

    // random traffic
    for (int it = 0; it < 600; it++) begin
      drive_id($urandom_range(0, 3) != 0, $urandom_range(0, 15), $urandom_range(0, 1),
               $urandom_range(0, 15), $urandom_range(0, 1), $urandom_range(0, 15),
               $urandom_range(0, 1));
      r = $urandom_range(0, 15);
      drive_wb($urandom_range(0, 1), r, $urandom_range(0, 3) != 0);
      if (wb_valid && wb_reg_write && r != 0 && m_cnt[r] == 0) wb_valid = 0;
      k = $urandom_range(0, 15);
      drive_kill($urandom_range(0, 5) == 0, k, 1);
      avail = m_cnt[k] - ((wb_valid && wb_reg_write && int'(wb_rd) == k) ? 1 : 0);
      if (kill_valid && k != 0 && avail < 1) kill_valid = 0;
      eval("rnd"); tick("rnd");
    end
    idle();

    // async reset with count[3]=2 and a live stall
    drive_id(1, 0, 0, 0, 0, 3, 1);
    eval("arst.fill"); tick("arst.fill");
    eval("arst.fill"); tick("arst.fill");
    drive_id(1, 3, 1, 0, 0, 4, 1);
    eval("arst.stall");
    tick("arst.stall");
    eval("arst.stall2");
    check("arst.stall_live", 64'(Mux_sel), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    check("arst.pc_en", 64'(PC_En), 64'd1);
    check("arst.if_id_en", 64'(IF_ID_En), 64'd1);
    check("arst.mux_sel", 64'(Mux_sel), 64'd0);
    check("arst.busy", 64'(busy), 64'd0);
    check("arst.stall_cycles", 64'(stall_cycles), 64'd0);
    model_reset();
    idle();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk) #1;
    drive_id(1, 3, 1, 0, 0, 4, 1);
    eval("arst.restart");
    check("arst.restart_no_stall", 64'(Mux_sel), 64'd0);
    tick("arst.restart");
    idle();

    // report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
